// File: rtl/reg_writeback.sv
// Write-back sequencer: buffers retired results in a small FIFO and drives the
// register file's skewed PREP/COMMIT write port, clearing r0..r7 after reset.
module reg_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_reg_num,
    input  logic [15:0]      in_data,
    output logic [2:0]       write_register_num,
    output logic [15:0]      write_register_in,
    output logic             write_en,
    output logic [7:0]       busy_mask,
    output logic [CNT_W-1:0] fifo_count,
    output logic             init_done
);

    localparam int unsigned NUM_W  = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned BUSY_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [NUM_W-1:0]  num;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [2:0] {
        S_INIT_PREP,
        S_INIT_COMMIT,
        S_IDLE,
        S_PREP,
        S_COMMIT
    } state_t;

    state_t              r_state, w_state_next;
    logic [NUM_W-1:0]    r_init_idx, w_init_idx_next;
    wb_entry_t           r_fifo [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count, w_count_next;
    logic [BUSY_W-1:0]   r_busy_cnt [NREG];
    logic [BUSY_W-1:0]   w_busy_cnt_next [NREG];
    logic [NREG-1:0]     r_busy_mask, w_busy_mask_next;
    logic [NUM_W-1:0]    r_num, w_num_next;
    logic [DATA_W-1:0]   r_data, w_data_next;
    logic                r_en, w_en_next;
    logic                r_init_done, w_init_done_next;
    logic                r_in_ready, w_in_ready_next;
    logic                w_push, w_pop, w_commit;
    wb_entry_t           w_head;
    logic [DATA_W-1:0]   w_head_data;

    assign w_push      = in_valid && r_in_ready;
    assign w_commit    = (r_state == S_COMMIT);
    assign w_head      = r_fifo[r_rd_ptr];
    // r0 is hard-wired to zero in the file, so never send it anything else
    assign w_head_data = (w_head.num == '0) ? '0 : w_head.data;

    // Next-state and registered-output decode
    always_comb begin
        w_state_next     = r_state;
        w_init_idx_next  = r_init_idx;
        w_num_next       = r_num;
        w_data_next      = r_data;
        w_en_next        = 1'b0;
        w_init_done_next = r_init_done;
        w_pop            = 1'b0;
        unique case (r_state)
            S_INIT_PREP: begin
                w_state_next = S_INIT_COMMIT;
                w_num_next   = r_init_idx;
                w_data_next  = '0;
                w_en_next    = 1'b1;
            end
            S_INIT_COMMIT: begin
                if (r_init_idx == NUM_W'(NREG - 1)) begin
                    w_state_next     = S_IDLE;
                    w_init_done_next = 1'b1;
                end else begin
                    w_state_next    = S_INIT_PREP;
                    w_init_idx_next = r_init_idx + NUM_W'(1);
                    w_num_next      = r_init_idx + NUM_W'(1);
                    w_data_next     = '0;
                end
            end
            S_IDLE, S_COMMIT: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_PREP;
                    w_num_next   = w_head.num;
                    w_data_next  = w_head_data;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_PREP: begin
                w_state_next = S_COMMIT;
                w_en_next    = 1'b1;
            end
            default: w_state_next = S_INIT_PREP;
        endcase
    end

    // Occupancy and ready, ready derived from the next registered count
    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
        w_in_ready_next = w_init_done_next && (w_count_next < FULL_CNT);
    end

    // Per-register outstanding-write counts; r0 is never tracked
    always_comb begin
        w_busy_cnt_next  = r_busy_cnt;
        w_busy_mask_next = '1;
        for (int n = 0; n < NREG; n++) begin
            if (n != 0) begin
                unique case ({w_push && (in_reg_num == NUM_W'(n)),
                              w_commit && (r_num == NUM_W'(n))})
                    2'b10:   w_busy_cnt_next[n] = r_busy_cnt[n] + BUSY_W'(1);
                    2'b01:   w_busy_cnt_next[n] = r_busy_cnt[n] - BUSY_W'(1);
                    default: w_busy_cnt_next[n] = r_busy_cnt[n];
                endcase
            end
            if (w_init_done_next) begin
                w_busy_mask_next[n] = (w_busy_cnt_next[n] != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT_PREP;
            r_init_idx  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_busy_mask <= '1;
            r_num       <= '0;
            r_data      <= '0;
            r_en        <= 1'b0;
            r_init_done <= 1'b0;
            r_in_ready  <= 1'b0;
            for (int n = 0; n < NREG; n++) begin
                r_busy_cnt[n] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_init_idx  <= w_init_idx_next;
            r_count     <= w_count_next;
            r_busy_mask <= w_busy_mask_next;
            r_num       <= w_num_next;
            r_data      <= w_data_next;
            r_en        <= w_en_next;
            r_init_done <= w_init_done_next;
            r_in_ready  <= w_in_ready_next;
            r_busy_cnt  <= w_busy_cnt_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload storage needs no reset; pointers qualify it
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {in_reg_num, in_data};
        end
    end

    assign in_ready           = r_in_ready;
    assign write_register_num = r_num;
    assign write_register_in  = r_data;
    assign write_en           = r_en;
    assign busy_mask          = r_busy_mask;
    assign fifo_count         = r_count;
    assign init_done          = r_init_done;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a behavioural model of the skewed
// register-file write port behind it.
module tb_reg_writeback;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_reg_num;
    logic [15:0]      in_data;
    logic [2:0]       write_register_num;
    logic [15:0]      write_register_in;
    logic             write_en;
    logic [7:0]       busy_mask;
    logic [CNT_W-1:0] fifo_count;
    logic             init_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] rf [8];
    logic [15:0] rf_hold;

    int          log_cyc  [$];
    logic [2:0]  log_num  [$];
    logic [15:0] log_data [$];
    logic        saw_full;
    int          full_ready_bad;

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_reg_num         (in_reg_num),
        .in_data            (in_data),
        .write_register_num (write_register_num),
        .write_register_in  (write_register_in),
        .write_en           (write_en),
        .busy_mask          (busy_mask),
        .fifo_count         (fifo_count),
        .init_done          (init_done)
    );

    // Register file: holding register loads while en is low, rN written when en is high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write_en) begin
            rf[write_register_num] <= rf_hold;
            if (init_done) begin
                log_cyc.push_back(cyc);
                log_num.push_back(write_register_num);
                log_data.push_back(write_register_in);
            end
        end else begin
            rf_hold <= write_register_in;
        end
        if (fifo_count == 3'd4) begin
            saw_full <= 1'b1;
            if (in_ready) full_ready_bad <= full_ready_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] n, input logic [15:0] d);
        int g = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_reg_num = n;
        in_data    = d;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("push_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while ((fifo_count != 0 || write_en || busy_mask != 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk(tag, 32'(g < 100), 32'd1);
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_num.delete();
        log_data.delete();
    endtask

    // Entered at the negedge of the first cycle after rst is released
    task automatic check_init(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk({tag, "_seq"},
                {write_register_num, write_en, write_register_in, busy_mask, init_done, in_ready},
                {2'b00, 3'(k / 2), 1'(k % 2), 16'h0000, 8'hFF, 1'b0, 1'b0});
            @(negedge clk);
        end
        chk({tag, "_done"}, {init_done, in_ready, busy_mask, write_en, fifo_count},
            {1'b1, 1'b1, 8'h00, 1'b0, 3'd0});
        for (int i = 0; i < 8; i++) chk({tag, "_rf_clear"}, 32'(rf[i]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected_cycles<%0d", cyc, 20000);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_reg_num = '0;
        in_data = '0;
        saw_full = 1'b0;
        full_ready_bad = 0;
        for (int i = 0; i < 8; i++) rf[i] = 16'hDEAD;
        repeat (3) @(negedge clk);
        chk("reset_port", {write_en, write_register_num, write_register_in, in_ready},
            {1'b0, 3'd0, 16'h0000, 1'b0});
        chk("reset_status", {busy_mask, fifo_count, init_done}, {8'hFF, 3'd0, 1'b0});
        rst = 1'b0;
        check_init("init");

        // Single write to r3
        push(3'd3, 16'h1234);
        chk("r3_t1", {fifo_count, busy_mask, write_en}, {3'd1, 8'h08, 1'b0});
        next_cycle();
        chk("r3_prep", {write_register_num, write_register_in, write_en}, {3'd3, 16'h1234, 1'b0});
        next_cycle();
        chk("r3_commit", {write_register_num, write_register_in, write_en}, {3'd3, 16'h1234, 1'b1});
        next_cycle();
        chk("r3_done", {busy_mask, fifo_count, write_en}, {8'h00, 3'd0, 1'b0});
        chk("r3_read", 32'(rf[3]), 32'h1234);

        // r0 write is forced to zero and never marked busy
        push(3'd0, 16'hBEEF);
        chk("r0_t1", {fifo_count, busy_mask}, {3'd1, 8'h00});
        next_cycle();
        chk("r0_prep", {write_register_num, write_register_in, write_en, busy_mask},
            {3'd0, 16'h0000, 1'b0, 8'h00});
        next_cycle();
        chk("r0_commit", {write_register_num, write_register_in, write_en, busy_mask},
            {3'd0, 16'h0000, 1'b1, 8'h00});
        next_cycle();
        chk("r0_read", 32'(rf[0]), 32'd0);

        // Six back-to-back pushes commit in order every two cycles
        clear_log();
        for (int i = 1; i <= 6; i++) push(3'(i), 16'(16'h0011 * i));
        wait_drain("burst_drain");
        chk("burst_count", 32'(log_num.size()), 32'd6);
        for (int i = 0; i < log_num.size() && i < 6; i++) begin
            chk("burst_num", 32'(log_num[i]), 32'(i + 1));
            chk("burst_data", 32'(log_data[i]), 32'(16'h0011 * (i + 1)));
            if (i > 0) chk("burst_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);
        end
        for (int i = 1; i <= 6; i++) chk("burst_rf", 32'(rf[i]), 32'(16'h0011 * i));

        // Seven pushes fill the FIFO; ready must be low whenever it is full
        clear_log();
        saw_full = 1'b0;
        full_ready_bad = 0;
        for (int i = 1; i <= 7; i++) push(3'(i), 16'(16'h0100 + i));
        wait_drain("fill_drain");
        chk("fill_reached_full", 32'(saw_full), 32'd1);
        chk("fill_ready_when_full", 32'(full_ready_bad), 32'd0);
        chk("fill_count", 32'(log_num.size()), 32'd7);
        for (int i = 0; i < log_num.size() && i < 7; i++)
            chk("fill_order", {log_num[i], log_data[i]}, {3'(i + 1), 16'(16'h0100 + i + 1)});

        // Two writes to r5: busy holds until the second commit
        push(3'd5, 16'hAAAA);
        push(3'd5, 16'h5555);
        chk("r5_prep1", {busy_mask, write_register_num, write_register_in, write_en},
            {8'h20, 3'd5, 16'hAAAA, 1'b0});
        next_cycle();
        chk("r5_commit1", {busy_mask, write_register_in, write_en}, {8'h20, 16'hAAAA, 1'b1});
        next_cycle();
        chk("r5_prep2", {busy_mask, write_register_in, write_en}, {8'h20, 16'h5555, 1'b0});
        chk("r5_read1", 32'(rf[5]), 32'hAAAA);
        next_cycle();
        chk("r5_commit2", {busy_mask, write_register_in, write_en}, {8'h20, 16'h5555, 1'b1});
        next_cycle();
        chk("r5_done", 32'(busy_mask), 32'h00);
        chk("r5_read2", 32'(rf[5]), 32'h5555);

        // Reset during the COMMIT of r2 with two entries still queued
        push(3'd2, 16'h2222);
        push(3'd3, 16'h3333);
        push(3'd4, 16'h4444);
        chk("rst_pre", {write_en, write_register_num, fifo_count}, {1'b1, 3'd2, 3'd2});
        rst = 1'b1;
        next_cycle();
        chk("rst_after", {write_en, fifo_count, busy_mask, init_done, in_ready},
            {1'b0, 3'd0, 8'hFF, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        check_init("reinit");
        chk("rst_r2_cleared", 32'(rf[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
